// File: rtl/fcmp_pkg.sv
// rtl/fcmp_pkg.sv - shared types, constants and field helpers for the fcmp arbiter slice
// Contents: fcmp_op_t compare opcodes, slot_state_t response-slot states,
//           FP_W / FP_EXP_MAX constants, fp_is_nan / fp_is_zero helpers.
package fcmp_pkg;

    localparam int       FP_W       = 32;
    localparam logic [7:0] FP_EXP_MAX = 8'd255;

    typedef enum logic [1:0] {
        FCMP_EQ  = 2'b00,
        FCMP_LT  = 2'b01,
        FCMP_LE  = 2'b10,
        FCMP_RSV = 2'b11
    } fcmp_op_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Any NaN, quiet or signalling.
    function automatic logic fp_is_nan(input logic [FP_W-1:0] v);
        return (v[30:23] == FP_EXP_MAX) && (v[22:0] != 23'd0);
    endfunction

    // +0 or -0.
    function automatic logic fp_is_zero(input logic [FP_W-1:0] v);
        return v[30:0] == 31'd0;
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// rtl/fcmp_core.sv - combinational single-precision EQ/LT/LE compare
// Ports: x1, x2 - IEEE-754 single operands
//        op     - fcmp_op_t encoding (EQ, LT, LE, reserved)
//        y      - compare result, 0 for NaN inputs or reserved op
//        nan    - at least one operand is NaN
module fcmp_core
    import fcmp_pkg::*;
(
    input  logic [FP_W-1:0] x1,
    input  logic [FP_W-1:0] x2,
    input  logic [1:0]      op,
    output logic            y,
    output logic            nan
);

    logic        s1;
    logic        s2;
    logic [30:0] m1;
    logic [30:0] m2;
    logic        both_zero;
    logic        eq;
    logic        lt;

    assign s1 = x1[31];
    assign s2 = x2[31];
    assign m1 = x1[30:0];
    assign m2 = x2[30:0];

    assign nan       = fp_is_nan(x1) || fp_is_nan(x2);
    assign both_zero = fp_is_zero(x1) && fp_is_zero(x2);

    // -0 and +0 are equal even though their bit patterns differ.
    assign eq = both_zero || (x1 == x2);

    // Sign-magnitude ordering; negative magnitudes compare reversed.
    always_comb begin
        lt = 1'b0;
        if (both_zero) begin
            lt = 1'b0;
        end else if (s1 != s2) begin
            lt = s1;
        end else if (!s1) begin
            lt = m1 < m2;
        end else begin
            lt = m1 > m2;
        end
    end

    always_comb begin
        y = 1'b0;
        if (!nan) begin
            case (fcmp_op_t'(op))
                FCMP_EQ:  y = eq;
                FCMP_LT:  y = lt;
                FCMP_LE:  y = lt || eq;
                FCMP_RSV: y = 1'b0;
                default:  y = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/fcmp_arb.sv
// rtl/fcmp_arb.sv - requester arbiter sharing one fcmp_core, with a one-entry response slot
// Config: FCMP_ARB_RR_EN defined -> round-robin from ptr; undefined -> fixed priority, lowest index wins.
// Ports: clk, rst (sync, active-high)
//        req_valid/req_ready [N_REQ]      - per-requester handshake, ready is one-hot or zero
//        req_op [N_REQ*2], req_x1/req_x2 [N_REQ*32] - packed per-requester op and operands
//        resp_valid/resp_ready            - response slot handshake
//        resp_id, resp_y, resp_nan        - registered response payload
module fcmp_arb
    import fcmp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*2-1:0]    req_op,
    input  logic [N_REQ*FP_W-1:0] req_x1,
    input  logic [N_REQ*FP_W-1:0] req_x2,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic                  resp_y,
    output logic                  resp_nan
);

    slot_state_t     state;
    logic            accept;
    logic            found;
    logic [ID_W-1:0] gnt_id;
    logic            hs;
    logic [1:0]      g_op;
    logic [FP_W-1:0] g_x1;
    logic [FP_W-1:0] g_x2;
    logic            c_y;
    logic            c_nan;
    int              idx;

`ifdef FCMP_ARB_RR_EN
    logic [ID_W-1:0] ptr;
`endif

    assign resp_valid = (state == SLOT_FULL);

    // Slot is free, or its current occupant leaves this same cycle.
    assign accept = !resp_valid || resp_ready;

    // Priority scan: from ptr when round-robin is built, from 0 otherwise.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef FCMP_ARB_RR_EN
            idx = (int'(ptr) + k) % N_REQ;
`else
            idx = k;
`endif
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
    end

    // Ready is masked during reset so nothing is consumed by a cycle whose
    // response would be thrown away.
    assign hs = found && accept && !rst;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Single shared comparator fed from the granted requester.
    always_comb begin
        g_op = req_op[int'(gnt_id)*2 +: 2];
        g_x1 = req_x1[int'(gnt_id)*FP_W +: FP_W];
        g_x2 = req_x2[int'(gnt_id)*FP_W +: FP_W];
    end

    fcmp_core u_core (
        .x1  (g_x1),
        .x2  (g_x2),
        .op  (g_op),
        .y   (c_y),
        .nan (c_nan)
    );

    // Slot FSM: EMPTY <-> FULL; a grant always (re)fills, a drain without grant empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SLOT_EMPTY;
            resp_y   <= 1'b0;
            resp_nan <= 1'b0;
            resp_id  <= '0;
`ifdef FCMP_ARB_RR_EN
            ptr      <= '0;
`endif
        end else if (hs) begin
            state    <= SLOT_FULL;
            resp_y   <= c_y;
            resp_nan <= c_nan;
            resp_id  <= gnt_id;
`ifdef FCMP_ARB_RR_EN
            ptr      <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
`endif
        end else if (resp_valid && resp_ready) begin
            state    <= SLOT_EMPTY;
        end
    end

endmodule

// File: tb/tb_fcmp_arb.sv
// tb/tb_fcmp_arb.sv - directed self-checking bench for fcmp_arb (N_REQ=4), both FCMP_ARB_RR_EN builds
module tb_fcmp_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_op;
    logic [127:0] req_x1;
    logic [127:0] req_x2;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic         resp_y;
    logic         resp_nan;

    int n_vec  = 0;
    int n_fail = 0;

`ifdef FCMP_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [1:0] OP_EQ  = 2'b00;
    localparam logic [1:0] OP_LT  = 2'b01;
    localparam logic [1:0] OP_LE  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    fcmp_arb #(.N_REQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x1     (req_x1),
        .req_x2     (req_x2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_nan   (resp_nan)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]        = 1'b1;
        req_op[i*2 +: 2]    = op;
        req_x1[i*32 +: 32]  = a;
        req_x2[i*32 +: 32]  = b;
    endtask

    // One request alone on requester i, accepted immediately, response checked next cycle.
    task automatic vec(input string tag, input int i, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ey, input logic en);
        req_valid = '0;
        set_req(i, op, a, b);
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(4'b0001 << i));
        tick();
        chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
        chk({tag, ".id"},    32'(resp_id),    32'(i));
        chk({tag, ".y"},     32'(resp_y),     32'(ey));
        chk({tag, ".nan"},   32'(resp_nan),   32'(en));
    endtask

    initial begin
        // Reset: ready masked during the reset cycle, outputs at reset values after it.
        rst        = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 4'b0001;
        req_op     = '0;
        req_x1     = '0;
        req_x2     = '0;
        #2;
        chk("rst.ready", 32'(req_ready), 32'd0);
        tick();
        chk("rst.valid", 32'(resp_valid), 32'd0);
        chk("rst.y",     32'(resp_y),     32'd0);
        chk("rst.nan",   32'(resp_nan),   32'd0);
        chk("rst.id",    32'(resp_id),    32'd0);
        req_valid = '0;
        rst       = 1'b0;
        tick();
        chk("idle.valid", 32'(resp_valid), 32'd0);

        // Single requests through the compare datapath.
        vec("lt_m1_p1",   0, OP_LT,  32'hBF800000, 32'h3F800000, 1'b1, 1'b0);
        vec("eq_zeros",   0, OP_EQ,  32'h80000000, 32'h00000000, 1'b1, 1'b0);
        vec("lt_zeros",   0, OP_LT,  32'h80000000, 32'h00000000, 1'b0, 1'b0);
        vec("le_nan",     0, OP_LE,  32'h7FC00000, 32'h3F800000, 1'b0, 1'b1);
        vec("eq_nan2",    0, OP_EQ,  32'h7FC00000, 32'h7FC00000, 1'b0, 1'b1);
        vec("lt_negs",    0, OP_LT,  32'hC0000000, 32'hBF800000, 1'b1, 1'b0);
        vec("le_pinf",    0, OP_LE,  32'h7F800000, 32'h3F800000, 1'b0, 1'b0);
        vec("rsv_eq",     0, OP_RSV, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
        vec("lt_ninf_r2", 2, OP_LT,  32'hFF800000, 32'h3F800000, 1'b1, 1'b0);
        vec("le_eq_r1",   1, OP_LE,  32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
        req_valid = '0;
        tick();
        chk("drain.valid", 32'(resp_valid), 32'd0);

        // Arbitration with all four requesters asserting.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, OP_LT, 32'hBF800000, 32'h3F800000);
        set_req(1, OP_EQ, 32'h3F800000, 32'h3F800000);
        set_req(2, OP_LE, 32'h40000000, 32'h3F800000);
        set_req(3, OP_LT, 32'h7FC00000, 32'h3F800000);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr%0d.ready", k), 32'(req_ready), RR ? 32'(4'b0001 << (k % 4)) : 32'd1);
            tick();
            chk($sformatf("rr%0d.id", k),    32'(resp_id),    RR ? 32'(k % 4) : 32'd0);
            chk($sformatf("rr%0d.valid", k), 32'(resp_valid), 32'd1);
        end

        // Backpressure: slot FULL (requester 0, y=1) held for three cycles.
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d.ready", k), 32'(req_ready), 32'd0);
            tick();
            chk($sformatf("bp%0d.valid", k), 32'(resp_valid), 32'd1);
            chk($sformatf("bp%0d.id", k),    32'(resp_id),    32'd0);
            chk($sformatf("bp%0d.y", k),     32'(resp_y),     32'd1);
            chk($sformatf("bp%0d.nan", k),   32'(resp_nan),   32'd0);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_rel.ready", 32'(req_ready), RR ? 32'b0010 : 32'b0001);
        tick();
        chk("bp_rel.valid", 32'(resp_valid), 32'd1);
        chk("bp_rel.id",    32'(resp_id),    RR ? 32'd1 : 32'd0);
        chk("bp_rel.y",     32'(resp_y),     32'd1);

        // Two idle cycles must not move the pointer.
        req_valid = '0;
        tick();
        chk("empty.valid", 32'(resp_valid), 32'd0);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("idle_ptr.ready", 32'(req_ready), RR ? 32'b1000 : 32'b0001);
        tick();
        chk("idle_ptr.id", 32'(resp_id), RR ? 32'd3 : 32'd0);

        // Reset right after a grant discards the response and rewinds the pointer.
        req_valid = 4'b0110;
        #1;
        chk("pre_rst.ready", 32'(req_ready), 32'b0010);
        tick();
        chk("pre_rst.valid", 32'(resp_valid), 32'd1);
        chk("pre_rst.id",    32'(resp_id),    32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst.ready", 32'(req_ready), 32'd0);
        tick();
        chk("mid_rst.valid", 32'(resp_valid), 32'd0);
        chk("mid_rst.id",    32'(resp_id),    32'd0);
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("post_rst.ready", 32'(req_ready), 32'b0001);
        tick();
        chk("post_rst.valid", 32'(resp_valid), 32'd1);
        chk("post_rst.id",    32'(resp_id),    32'd0);
        req_valid = '0;
        tick();
        chk("end.valid", 32'(resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fcmp_arb.md
# fcmp_arb

Round-robin arbiter and sequencer that shares one single-precision compare datapath (EQ/LT/LE, with IEEE-754 NaN and signed-zero rules) among several requesters. The arbiter, the compare logic and a one-entry registered response slot with valid/ready handshake make up the block. It sits between the integer/FP issue ports and the FPU compare logic, so that several pipelines can issue `feq`/`flt`/`fle` without duplicating comparators.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester index.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, `N_REQ` bits: one request-present bit per requester.
- `req_ready` output, `N_REQ` bits: request accepted this cycle, one-hot or zero.
- `req_op` input, `N_REQ`x2 bits: 00 EQ, 01 LT, 10 LE, 11 reserved.
- `req_x1`, `req_x2` input, `N_REQ`x32 bits: IEEE-754 single operands.
- `resp_valid` output, 1 bit: response slot full.
- `resp_ready` input, 1 bit: consumer takes the response.
- `resp_id` output, `ID_W` bits: index of the requester that issued the response.
- `resp_y` output, 1 bit: compare result.
- `resp_nan` output, 1 bit: at least one operand was NaN (invalid flag).

## Operation
- `accept = !resp_valid || resp_ready`. This is the slot free or draining in the same cycle.
- Grant, combinational:
  - Scan the requesters starting at `ptr` and pick the first `i` with `req_valid[i]`.
  - `req_ready[i] = grant[i] && accept`. All other ready bits are 0.
- Compare datapath, combinational on the granted operands:
  - NaN: exponent 255 with a nonzero mantissa. If either operand is NaN: `y=0`, `nan=1`.
  - If both operands are ±0 (exponent and mantissa zero): EQ, LE give 1; LT gives 0.
  - Otherwise order by sign-magnitude:
    - Signs differ: the negative operand is smaller.
    - Both positive: compare the unsigned magnitudes.
    - Both negative: compare the unsigned magnitudes with the order reversed.
  - ±Inf orders normally.
  - Reserved op gives `y=0`, with `nan` still computed.
- On handshake (`req_valid[i] && req_ready[i]`):
  - Register `resp_y`, `resp_nan`, `resp_id=i`. Set `resp_valid=1`.
  - Set `ptr = (i+1) mod N_REQ`.
- Otherwise, if `resp_ready && resp_valid`, clear `resp_valid`.
- Request-side protocol:
  - While `req_valid[i] && !req_ready[i]`, the requester holds op and operands stable and does not drop valid.
  - `req_ready` does not depend combinationally on `resp_valid` of any other instance.
- Response-side protocol:
  - While `resp_valid && !resp_ready`, all `resp_*` outputs are held stable.
- State is a 2-state slot, EMPTY (`resp_valid=0`) and FULL (`resp_valid=1`):
  - EMPTY to FULL on grant.
  - FULL to FULL on drain and grant in the same cycle.
  - FULL to EMPTY on drain with no grant.

## Timing
- Reset values: `resp_valid=0`, `resp_y=0`, `resp_nan=0`, `resp_id=0`, `ptr=0`.
- `req_ready` is 0 during the reset cycle.
- Latency: a request accepted in cycle t has its response visible in cycle t+1.
- Throughput: one compare per cycle while `resp_ready=1`.
- Backpressure: with `resp_ready=0` and the slot FULL, every `req_ready=0`.
- Drain and accept in the same cycle gives a full-rate handoff with no bubble.
- `ptr` advances only on a grant, never on an idle cycle.
- Reset mid-operation: any in-flight response is discarded and no `resp_valid` pulse follows.

## Configuration
- `FCMP_ARB_RR_EN`
  - Defined: round-robin `ptr` as described above.
  - Undefined: fixed priority, lowest index wins, and no `ptr` register is built. Starvation of high indices is then permitted by design.

## Structure
- Package `fcmp_pkg` holds:
  - `typedef enum logic [1:0] fcmp_op_t {FCMP_EQ, FCMP_LT, FCMP_LE, FCMP_RSV}`.
  - The constants `FP_EXP_MAX = 8'd255` and `FP_W = 32`.
- Sub-module `fcmp_core` is purely combinational: `x1`, `x2`, `op` in; `y`, `nan` out. The arbiter instantiates it exactly once on the granted mux output.

## Test plan
1. Single request with `resp_ready=1`. Req0: LT, x1 `0xBF800000` (-1.0), x2 `0x3F800000` (1.0). Required: `req_ready[0]=1` in that cycle; next cycle `resp_valid=1`, `resp_id=0`, `resp_y=1`, `resp_nan=0`.
2. Signed zero. EQ with `0x80000000` vs `0x00000000` gives `y=1`. LT on the same operands gives `y=0`.
3. NaN. LE with `0x7FC00000` vs `0x3F800000` gives `y=0`, `nan=1`. EQ with both operands `0x7FC00000` gives `y=0`, `nan=1`.
4. Round robin under `FCMP_ARB_RR_EN`, `N_REQ=4`, all four `req_valid` held high and `resp_ready=1`. Required grant order 0,1,2,3,0, with `resp_id` following one cycle later. Without the macro the grant is 0 on every cycle.
5. Backpressure. Hold `resp_ready=0` for 3 cycles while FULL with `resp_y=1`. Required: all `req_ready=0` and `resp_*` stable. Raising `resp_ready` drains and accepts in the same cycle.
6. Apply `rst` for one cycle immediately after a grant. Required: `resp_valid=0` on the following cycle, `ptr` back to 0, and the next grant goes to requester 0.
